// File: rtl/rotate_stage.sv
// Iterative 32-bit rotator: one amount bit per cycle over five ROT cycles,
// with the key word carried alongside so downstream can form rot(A) ^ B.
module rotate_stage #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_key,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_key
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [2:0]       step;
    logic [WIDTH-1:0] data_r, key_r;
    logic [SHW-1:0]   amt_r;
    logic             dir_r;

    // Rotate by 2^s using a doubled word so bits leaving one end re-enter the other.
    function automatic logic [WIDTH-1:0] rot_pow2(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       s,
                                                  input logic             right);
        logic [2*WIDTH-1:0] dbl;
        logic [SHW-1:0]     n;
        n   = SHW'(1) << s;
        dbl = {d, d};
        if (right) begin
            dbl = dbl >> n;
            return dbl[WIDTH-1:0];
        end
        dbl = dbl << n;
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ROT;
            ROT:     if (step == 3'd4) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step   <= 3'd0;
            data_r <= '0;
            key_r  <= '0;
            amt_r  <= '0;
            dir_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r <= in_data;
                        key_r  <= in_key;
                        amt_r  <= in_amt;
                        dir_r  <= in_dir;
                        step   <= 3'd0;
                    end
                end
                ROT: begin
                    if (amt_r[step]) data_r <= rot_pow2(data_r, step, dir_r);
                    step <= step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only; data is masked outside DONE so
    // intermediate rotation steps never appear on the bus.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? data_r : '0;
    assign out_key   = (state == DONE) ? key_r  : '0;

endmodule

// File: tb/tb_rotate_stage.sv
// Self-checking bench for rotate_stage: directed cases, backpressure, mid-flight
// reset and a randomized sweep against a bit-index rotate model.
module tb_rotate_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_key;
    logic [4:0]  in_amt;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_key;

    int n_vec  = 0;
    int n_fail = 0;

    rotate_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_key   (out_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rotate: move each bit to its destination index modulo 32.
    function automatic logic [31:0] model_rot(input logic [31:0] d, input int n, input logic right);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (right) r[i] = d[(i + n) % 32];
            else       r[(i + n) % 32] = d[i];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] d, input logic [31:0] k,
                            input logic [4:0] a, input logic dr);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_amt   = a;
        in_dir   = dr;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_key   = $urandom;
        in_amt   = 5'($urandom);
        in_dir   = 1'($urandom);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result(input logic [31:0] d, input logic [31:0] k,
                               input logic [4:0] a, input logic dr, input bit rand_rdy);
        int cyc;
        logic [31:0] exp;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            if (rand_rdy) out_ready = 1'($urandom);
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'd5);
        exp = model_rot(d, int'(a), dr);
        check("out_data", out_data, exp);
        check("out_key", out_key, k);
        check("xor_f", out_data ^ out_key, exp ^ k);
    endtask

    task automatic drain(input logic [31:0] exp_d, input logic [31:0] exp_k, input bit rand_rdy);
        int  cyc;
        logic r;
        cyc = 0;
        do begin
            r = rand_rdy ? 1'($urandom) : 1'b1;
            if (cyc > 40) r = 1'b1;
            out_ready = r;
            tick();
            cyc++;
            if (!r) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, exp_d);
                check("hold_key", out_key, exp_k);
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end while (!r);
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_rise", 32'(in_ready), 32'd1);
    endtask

    task automatic full_op(input logic [31:0] d, input logic [31:0] k,
                           input logic [4:0] a, input logic dr, input bit rand_rdy);
        start_op(d, k, a, dr);
        wait_result(d, k, a, dr, rand_rdy);
        drain(model_rot(d, int'(a), dr), k, rand_rdy);
    endtask

    initial begin
        logic [31:0] d, k, exp;
        logic [4:0]  a;
        logic        dr;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_key", out_key, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases from the expected-value table.
        full_op(32'h80000001, 32'h5A5A1234, 5'd1, 1'b0, 1'b0);
        check("dir_l1", model_rot(32'h80000001, 1, 1'b0), 32'h00000003);
        full_op(32'h12345678, 32'h0BADF00D, 5'd4, 1'b1, 1'b0);
        check("dir_r4", model_rot(32'h12345678, 4, 1'b1), 32'h81234567);
        full_op(32'h00000001, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b0);
        full_op(32'hDEADBEEF, 32'h00000000, 5'd8, 1'b0, 1'b0);
        full_op(32'hCAFEF00D, 32'h13572468, 5'd0, 1'b1, 1'b0);
        full_op(32'hCAFEF00D, 32'h13572468, 5'd31, 1'b1, 1'b0);

        // Backpressure: hold DONE for 10 cycles with a new request pending.
        start_op(32'hA5C3_0F1E, 32'h1122_3344, 5'd13, 1'b1);
        wait_result(32'hA5C3_0F1E, 32'h1122_3344, 5'd13, 1'b1, 1'b0);
        exp = model_rot(32'hA5C3_0F1E, 13, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0000_00F0;
        in_key   = 32'h7777_7777;
        in_amt   = 5'd4;
        in_dir   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, exp);
            check("bp_key", out_key, 32'h1122_3344);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_idle_cycle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_accept", 32'(in_ready), 32'd0);
        wait_result(32'h0000_00F0, 32'h7777_7777, 5'd4, 1'b0, 1'b0);
        drain(32'h0000_0F00, 32'h7777_7777, 1'b0);

        // Requests during ROT must be ignored.
        start_op(32'h0F0F_0001, 32'hBEEF_CAFE, 5'd17, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_key   = $urandom;
            tick();
        end
        in_valid = 1'b0;
        begin
            int cyc;
            cyc = 3;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            check("ign_latency", 32'(cyc), 32'd5);
        end
        exp = model_rot(32'h0F0F_0001, 17, 1'b0);
        check("ign_data", out_data, exp);
        check("ign_key", out_key, 32'hBEEF_CAFE);
        drain(exp, 32'hBEEF_CAFE, 1'b0);

        // Asynchronous reset during the third ROT cycle.
        start_op(32'h1234_ABCD, 32'h9999_0000, 5'd31, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_key", out_key, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("arst_no_result", 32'(out_valid), 32'd0);
        full_op(32'h8000_0000, 32'h0000_FFFF, 5'd3, 1'b1, 1'b0);

        // Randomized sweep under random downstream backpressure.
        for (int t = 0; t < 1000; t++) begin
            d  = $urandom;
            k  = $urandom;
            a  = 5'($urandom);
            dr = 1'($urandom);
            full_op(d, k, a, dr, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rotate_stage.md
# rotate_stage

Iterative 32-bit rotator with valid/ready handshakes on both sides. It is the stage directly upstream of the 32-bit XOR block and produces the aligned operand pair that the XOR consumes, so that F = rot(A) ^ B. Each operation rotates the data word left or right by 0–31 positions using a logarithmic schedule of one amount bit per cycle. The key word passes through unchanged, registered alongside the result.

## Interface
- WIDTH, 32, data and key width; fixed at 32 for this revision.
- SHW, 5, rotate-amount width; always log2(WIDTH).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers an operation.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  32  word to rotate (XOR operand A).
- in_key  in  32  pass-through operand (XOR operand B).
- in_amt  in  5  rotate amount, 0–31.
- in_dir  in  1  0 = rotate left, 1 = rotate right.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  rotated word; feeds XOR input A.
- out_key  out  32  captured in_key; feeds XOR input B.

## Operation
- Registers: state (IDLE/ROT/DONE), step counter (3 bits, 0–4), data_r, key_r, amt_r, dir_r.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data, in_key, in_amt and in_dir; clear step to 0; go to ROT.
- ROT
  - in_ready = 0.
  - Each cycle: if amt_r[step] = 1, rotate data_r by 2^step in direction dir_r; otherwise hold data_r.
  - Increment step. When step = 4 completes, go to DONE.
  - Exactly 5 ROT cycles, independent of amount value.
- DONE
  - out_valid = 1; out_data = data_r; out_key = key_r.
  - On out_ready: go to IDLE.
  - Without out_ready, hold all outputs stable indefinitely.
- Rotation is a true rotate: bits shifted out re-enter at the opposite end, no loss, no sign fill.
  - Amount 0 returns in_data unchanged.
  - Left by n equals right by (32−n) mod 32.
- key_r is never modified between capture and output.
- in_valid while not in IDLE is ignored; upstream must hold its request until in_ready.
- No new operation is accepted in the cycle out_valid handshakes. IDLE always lasts at least one cycle.
- Reset, asynchronous at any time including mid-ROT or DONE:
  - Sets state to IDLE, step 0, out_valid 0, out_data 0, out_key 0, and internal registers 0.
  - Any in-flight operation is discarded; no partial result is ever presented.
  - in_ready reads 1 once state is IDLE. Capture cannot occur while rst is high.

## Timing
- Accept at edge k, then ROT edges k+1 to k+5, then out_valid high after edge k+5.
- Latency is 5 cycles from accept edge to out_valid.
- Minimum initiation interval is 7 cycles: 1 IDLE + 5 ROT + 1 DONE with out_ready already high.
- out_valid drops on the edge where out_valid & out_ready, and in_ready rises on that same edge.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Reset, then left rotate of 0x80000001 by 1 with out_ready = 1: out_valid after 5 cycles, out_data = 0x00000003, out_key equals the input key.
- Right rotate of 0x12345678 by 4 gives 0x81234567. Left rotate of 0x00000001 by 31 gives 0x80000000. Left rotate of 0xDEADBEEF by 8 gives 0xADBEEFDE. Amount 0 on 0xCAFEF00D returns 0xCAFEF00D, still with 5-cycle latency.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE.
  - out_valid, out_data and out_key stay stable and in_ready stays 0.
  - Raising out_ready completes one transfer, followed by one IDLE cycle.
- Change in_data and assert in_valid during ROT: the input is ignored and the result reflects only the captured operands.
- Assert rst on the third ROT cycle:
  - out_valid = 0 and out_data/out_key = 0 immediately, without waiting for a clock.
  - After release, a fresh operation completes correctly in 5 cycles.
- Random sweep with a model: 1000 random data/key/amount/direction sets under random out_ready. Every transfer matches the model rotate, and (out_data ^ out_key) matches the downstream XOR expectation.
